// File: rtl/decode_stage.sv
// decode_stage: register file plus registered ID/EX stage for 32-bit instructions.
// Field layout: op[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   if_valid/if_ready      fetch handshake (if_ready is combinational)
//   if_npc, if_ir          next PC and instruction from fetch
//   wb_en/wb_addr/wb_data  synchronous register-file writeback
//   flush                  kills stage contents and clears halt
//   id_valid/id_ready      execute handshake
//   id_a/id_b/id_d         reg[rs1], reg[rs2], reg[rd]
//   id_imm, id_npc, id_ir  sign-extended immediate, captured NPC and IR
//   halted                 sticky halt status
module decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter logic [5:0]  HALT_OP      = 6'h3F,
  parameter bit          HOLD_REFRESH = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_npc,
  input  logic [31:0]     if_ir,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_a,
  output logic [XLEN-1:0] id_b,
  output logic [XLEN-1:0] id_d,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_npc,
  output logic [31:0]     id_ir,
  output logic            halted
);

  localparam int unsigned RF_DEPTH = 32;

  // Full 5-bit index space; entries at or above NREG are never written.
  logic [XLEN-1:0] regs [RF_DEPTH];

  logic            accept_c;
  logic            valid_n;
  logic            halted_n;
  logic [XLEN-1:0] a_n;
  logic [XLEN-1:0] b_n;
  logic [XLEN-1:0] d_n;
  logic [XLEN-1:0] imm_n;
  logic [XLEN-1:0] npc_n;
  logic [31:0]     ir_n;

  // Index names a real, writable register (not R0, below NREG).
  function automatic logic in_range(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NREG);
  endfunction

  // An enabled writeback this cycle targets idx.
  function automatic logic wb_hit(input logic en, input logic [4:0] waddr,
                                  input logic [4:0] idx);
    return en && (waddr == idx) && in_range(idx);
  endfunction

  // Read port with same-cycle write-to-read bypass.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx, input logic en,
                                                input logic [4:0] waddr,
                                                input logic [XLEN-1:0] wdata,
                                                input logic [XLEN-1:0] stored);
    if (!in_range(idx)) return '0;
    if (wb_hit(en, waddr, idx)) return wdata;
    return stored;
  endfunction

  assign if_ready = !halted && (!id_valid || id_ready);
  assign accept_c = if_valid && if_ready && !flush;

  // Register file write port; writes proceed regardless of handshake or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) regs[i] <= '0;
    end else if (wb_en && in_range(wb_addr)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Next-state for the ID/EX register: flush > accept > consume > stall refresh.
  always_comb begin
    valid_n  = id_valid;
    halted_n = halted;
    a_n      = id_a;
    b_n      = id_b;
    d_n      = id_d;
    imm_n    = id_imm;
    npc_n    = id_npc;
    ir_n     = id_ir;
    if (flush) begin
      valid_n  = 1'b0;
      halted_n = 1'b0;
    end else if (accept_c) begin
      valid_n = 1'b1;
      a_n     = read_port(if_ir[20:16], wb_en, wb_addr, wb_data, regs[if_ir[20:16]]);
      b_n     = read_port(if_ir[15:11], wb_en, wb_addr, wb_data, regs[if_ir[15:11]]);
      d_n     = read_port(if_ir[25:21], wb_en, wb_addr, wb_data, regs[if_ir[25:21]]);
      imm_n   = XLEN'($signed(if_ir[15:0]));
      npc_n   = if_npc;
      ir_n    = if_ir;
      if (if_ir[31:26] == HALT_OP) halted_n = 1'b1;
    end else if (id_valid && id_ready) begin
      valid_n = 1'b0;
    end else if (id_valid && HOLD_REFRESH) begin
      // Stalled operands follow writebacks to their captured indices.
      if (wb_hit(wb_en, wb_addr, id_ir[20:16])) a_n = wb_data;
      if (wb_hit(wb_en, wb_addr, id_ir[15:11])) b_n = wb_data;
      if (wb_hit(wb_en, wb_addr, id_ir[25:21])) d_n = wb_data;
    end
  end

  // ID/EX stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      halted   <= 1'b0;
      id_a     <= '0;
      id_b     <= '0;
      id_d     <= '0;
      id_imm   <= '0;
      id_npc   <= '0;
      id_ir    <= '0;
    end else begin
      id_valid <= valid_n;
      halted   <= halted_n;
      id_a     <= a_n;
      id_b     <= b_n;
      id_d     <= d_n;
      id_imm   <= imm_n;
      id_npc   <= npc_n;
      id_ir    <= ir_n;
    end
  end

endmodule
